// File: rtl/hp_manager.sv
// Player and monster hit-point bookkeeping for the battle screen.
// Strike position -> zone damage; heart/ball collisions -> rate-limited hits.
module hp_manager #(
   parameter logic [15:0] PLAYER_MAX_HP   = 16'd300,
   parameter logic [15:0] MONSTER_MAX_HP  = 16'd500,
   parameter logic [15:0] HIT_DAMAGE      = 16'd20,
   parameter logic [15:0] COOLDOWN_FRAMES = 16'd30,
   parameter logic [15:0] CENTER_X        = 16'd315,
   parameter logic [15:0] GREEN_HALF      = 16'd10,
   parameter logic [15:0] YELLOW_HALF     = 16'd95,
   parameter logic [15:0] ORANGE_HALF     = 16'd155,
   parameter logic [15:0] BLUE_HALF       = 16'd200,
   parameter logic [15:0] GREEN_DMG       = 16'd100,
   parameter logic [15:0] YELLOW_DMG      = 16'd60,
   parameter logic [15:0] ORANGE_DMG      = 16'd30,
   parameter logic [15:0] BLUE_DMG        = 16'd10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_new_game,
   input  logic        i_strike,
   input  logic [15:0] i_strike_x,
   input  logic        i_collide,
   input  logic        i_animate,
   output logic [15:0] o_player_hp,
   output logic [15:0] o_monster_hp,
   output logic        o_player_dead,
   output logic        o_monster_dead,
   output logic [15:0] o_damage,
   output logic        o_dmg_valid,
   output logic        o_player_hit
);

   typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_APPLY} state_t;

   state_t      state, state_nx;
   logic [15:0] x_r, dist_r, dmg_r;
   logic [15:0] dist_nx, dmg_sel, mon_nx, ply_nx;
   logic [15:0] cooldown;
   logic        apply_q, latch, hit, take;

   assign take = (state == S_IDLE) && i_strike && !o_monster_dead;
   assign hit  = latch | i_collide;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (take) state_nx = S_MEASURE;
         S_MEASURE: state_nx = S_APPLY;
         S_APPLY:   state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      dist_nx = (x_r >= CENTER_X) ? x_r - CENTER_X : CENTER_X - x_r;
      if (dist_r <= GREEN_HALF)       dmg_sel = GREEN_DMG;
      else if (dist_r <= YELLOW_HALF) dmg_sel = YELLOW_DMG;
      else if (dist_r <= ORANGE_HALF) dmg_sel = ORANGE_DMG;
      else if (dist_r <= BLUE_HALF)   dmg_sel = BLUE_DMG;
      else                            dmg_sel = '0;
      mon_nx = (o_monster_hp > dmg_r) ? o_monster_hp - dmg_r : '0;
      ply_nx = (o_player_hp > HIT_DAMAGE) ? o_player_hp - HIT_DAMAGE : '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_new_game) begin
         state          <= S_IDLE;
         x_r            <= '0;
         dist_r         <= '0;
         dmg_r          <= '0;
         apply_q        <= 1'b0;
         o_damage       <= '0;
         o_dmg_valid    <= 1'b0;
         o_monster_hp   <= MONSTER_MAX_HP;
         o_monster_dead <= 1'b0;
         o_player_hp    <= PLAYER_MAX_HP;
         o_player_dead  <= 1'b0;
         o_player_hit   <= 1'b0;
         cooldown       <= '0;
         latch          <= 1'b0;
      end else begin
         state       <= state_nx;
         apply_q     <= (state == S_APPLY);
         o_dmg_valid <= apply_q;
         if (take)                x_r    <= i_strike_x;
         if (state == S_MEASURE)  dist_r <= dist_nx;
         if (state == S_APPLY)    dmg_r  <= dmg_sel;
         // Final commit stage: damage, HP and dead flag land together.
         if (apply_q) begin
            o_damage       <= dmg_r;
            o_monster_hp   <= mon_nx;
            o_monster_dead <= (mon_nx == '0);
         end

         o_player_hit <= 1'b0;
         if (i_animate) begin
            latch <= 1'b0;
            if (cooldown != '0) begin
               cooldown <= cooldown - 16'd1;
            end else if (hit && !o_player_dead) begin
               o_player_hp   <= ply_nx;
               o_player_dead <= (ply_nx == '0);
               cooldown      <= COOLDOWN_FRAMES;
               o_player_hit  <= 1'b1;
            end
         end else if (i_collide) begin
            latch <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hp_manager.sv
// Scoreboard bench for hp_manager: randomized strikes and collision frames
// checked against a plain-arithmetic game model.
module tb_hp_manager;

   logic        i_clk = 1'b0;
   logic        i_rst, i_new_game, i_strike, i_collide, i_animate;
   logic [15:0] i_strike_x;
   logic [15:0] o_player_hp, o_monster_hp, o_damage;
   logic        o_player_dead, o_monster_dead, o_dmg_valid, o_player_hit;

   hp_manager dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_new_game(i_new_game),
      .i_strike(i_strike), .i_strike_x(i_strike_x),
      .i_collide(i_collide), .i_animate(i_animate),
      .o_player_hp(o_player_hp), .o_monster_hp(o_monster_hp),
      .o_player_dead(o_player_dead), .o_monster_dead(o_monster_dead),
      .o_damage(o_damage), .o_dmg_valid(o_dmg_valid),
      .o_player_hit(o_player_hit)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int dmg;
      int hp;
      int cyc;
   } strike_exp_t;

   strike_exp_t sq[$];
   int          pq[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   // game model
   int m_mhp, m_php, m_cd;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int zone_dmg(int x);
      int d;
      d = (x > 315) ? x - 315 : 315 - x;
      if (d <= 10)  return 100;
      if (d <= 95)  return 60;
      if (d <= 155) return 30;
      if (d <= 200) return 10;
      return 0;
   endfunction

   // monitor: pops the scoreboard whenever the DUT pulses
   always @(negedge i_clk) begin
      if (o_dmg_valid) begin
         if (sq.size() == 0) begin
            check("unexpected_dmg_valid", 1, 0);
         end else begin
            strike_exp_t e;
            e = sq.pop_front();
            check("damage", int'(o_damage), e.dmg);
            check("monster_hp", int'(o_monster_hp), e.hp);
            check("monster_dead", int'(o_monster_dead), int'(e.hp == 0));
            check("strike_latency", cyc, e.cyc);
         end
      end
      if (o_player_hit) begin
         if (pq.size() == 0) begin
            check("unexpected_player_hit", 1, 0);
         end else begin
            int e;
            e = pq.pop_front();
            check("player_hp_on_hit", int'(o_player_hp), e);
            check("player_dead_on_hit", int'(o_player_dead), int'(e == 0));
         end
      end
   end

   task automatic push_strike(int x);
      strike_exp_t e;
      e.dmg = zone_dmg(x);
      m_mhp = (m_mhp > e.dmg) ? m_mhp - e.dmg : 0;
      e.hp  = m_mhp;
      e.cyc = cyc + 4;
      sq.push_back(e);
   endtask

   task automatic strike(int x);
      @(negedge i_clk);
      if (m_mhp > 0) push_strike(x);
      i_strike   = 1'b1;
      i_strike_x = 16'(x);
      @(negedge i_clk);
      i_strike = 1'b0;
      repeat (5) @(negedge i_clk);
   endtask

   // late: collide asserted on the same cycle as the animate strobe
   task automatic frame(bit col, bit late);
      bit hit;
      @(negedge i_clk);
      i_collide = col & ~late;
      @(negedge i_clk);
      i_collide = 1'b0;
      repeat (2) @(negedge i_clk);
      hit = col;
      if (m_cd > 0) begin
         m_cd--;
      end else if (hit && m_php > 0) begin
         m_php = (m_php > 20) ? m_php - 20 : 0;
         m_cd  = 30;
         pq.push_back(m_php);
      end
      i_animate = 1'b1;
      i_collide = col & late;
      @(negedge i_clk);
      i_animate = 1'b0;
      i_collide = 1'b0;
      check("player_hp_frame", int'(o_player_hp), m_php);
   endtask

   task automatic model_reset();
      m_mhp = 500;
      m_php = 300;
      m_cd  = 0;
   endtask

   int xs[12] = '{318, 305, 325, 220, 410, 160, 470, 115, 515, 114, 516, 600};

   initial begin
      i_rst = 1'b1; i_new_game = 1'b0; i_strike = 1'b0;
      i_strike_x = '0; i_collide = 1'b0; i_animate = 1'b0;
      model_reset();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_player_hp", int'(o_player_hp), 300);
      check("rst_monster_hp", int'(o_monster_hp), 500);
      check("rst_player_dead", int'(o_player_dead), 0);
      check("rst_monster_dead", int'(o_monster_dead), 0);
      check("rst_damage", int'(o_damage), 0);

      foreach (xs[i]) strike(xs[i]);

      // back-to-back strike: the second pulse lands in MEASURE
      @(negedge i_clk);
      if (m_mhp > 0) push_strike(300);
      i_strike = 1'b1; i_strike_x = 16'd300;
      @(negedge i_clk);
      i_strike_x = 16'd315;
      @(negedge i_clk);
      i_strike = 1'b0;
      repeat (5) @(negedge i_clk);

      for (int i = 0; i < 6; i++) strike(int'($urandom_range(0, 700)));
      for (int i = 0; i < 10 && m_mhp > 0; i++) strike(315);
      check("monster_hp_zero", int'(o_monster_hp), 0);
      check("monster_dead", int'(o_monster_dead), 1);
      strike(315);
      check("dead_monster_hp", int'(o_monster_hp), 0);

      frame(1'b1, 1'b0);
      for (int i = 0; i < 30; i++) frame(1'b1, i[0]);
      frame(1'b1, 1'b1);
      for (int i = 0; i < 200; i++) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 600 && m_php > 0; i++) frame(1'b1, 1'b0);
      check("player_hp_zero", int'(o_player_hp), 0);
      check("player_dead", int'(o_player_dead), 1);
      frame(1'b1, 1'b0);

      // strike aborted by new game on the next cycle
      @(negedge i_clk);
      i_strike = 1'b1; i_strike_x = 16'd315;
      @(negedge i_clk);
      i_strike = 1'b0; i_new_game = 1'b1;
      @(negedge i_clk);
      i_new_game = 1'b0;
      model_reset();
      repeat (6) @(negedge i_clk);
      check("ng_monster_hp", int'(o_monster_hp), 500);
      check("ng_player_hp", int'(o_player_hp), 300);
      check("ng_monster_dead", int'(o_monster_dead), 0);
      check("ng_player_dead", int'(o_player_dead), 0);
      check("ng_damage", int'(o_damage), 0);
      frame(1'b1, 1'b0);
      strike(220);

      repeat (8) @(negedge i_clk);
      check("strike_queue_drained", sq.size(), 0);
      check("hit_queue_drained", pq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
